// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding and byte-enable legality.
package dm_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dm_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Single bytes, aligned halves, the full word and the empty no-op are the only naturally aligned shapes.
    function automatic logic legal_be(input logic [3:0] be);
        logic ok;
        ok = 1'b0;
        case (be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            BE_HALF_LO, BE_HALF_HI, BE_WORD: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Core-to-data-memory request/response channels, each with its own valid/ready handshake.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_sram.sv
// Word-addressed storage with one synchronous byte-enabled write port and one registered read port.
// Read returns the content before a same-edge write; no reset, contents are cleared by the owner.
module dm_sram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [3:0]    wr_be_i,
    input  logic [31:0]   wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_i[i]) mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, byte-enabled write or word read; DM_ALIGN_CHECK_EN adds misalignment errors.
// Response valid WAIT_CYCLES+1 cycles after accept; held until rsp_ready, no new accept until then.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus,
    output logic          busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dm_state_t     state_q;
    logic [AW-1:0] clr_cnt_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic          bad_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          busy_q;

    logic [31:0]   off;
    logic [AW-1:0] dec_idx;
    logic          dec_oor;
    logic          dec_mis;
    logic          unused_lsb;

    assign off        = bus.req_addr - BASE_ADDR;
    assign dec_idx    = off[AW+1:2];
    assign dec_oor    = |off[31:AW+2];
    assign unused_lsb = ^off[1:0];

`ifdef DM_ALIGN_CHECK_EN
    assign dec_mis = (bus.req_addr[1:0] != 2'b00) || !legal_be(bus.req_be);
`else
    assign dec_mis = 1'b0;
`endif

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;

    // The write lands on the RESP entry edge; the read was already captured one edge earlier.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx_q;
        wr_be   = be_q;
        wr_data = wdata_q;
        rd_addr = (state_q == IDLE) ? dec_idx : idx_q;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_q;
            wr_be   = BE_WORD;
            wr_data = '0;
        end else if (state_q == WAIT && cnt_q == 4'd0 && we_q && !bad_q) begin
            wr_en = 1'b1;
        end
    end

    dm_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_be_i   (wr_be),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // WAIT always spans WAIT_CYCLES+1 cycles: the extra cycle is the RAM's registered read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        bad_q       <= dec_oor || dec_mis;
                        idx_q       <= dec_idx;
                        wdata_q     <= bus.req_wdata;
                        be_q        <= bus.req_be;
                        cnt_q       <= 4'(WAIT_CYCLES);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bad_q;
                        rsp_rdata_q <= (we_q || bad_q) ? 32'h0 : rd_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;

endmodule
